// File: rtl/read_hazard_ctrl.sv
// read_hazard_ctrl: issue controller beside the register-read stage.
// Tracks in-flight register writes in a busy scoreboard and stalls the read
// stage on RAW/WAW hazards or when the in-flight budget is exhausted.
// FENCE/SYSTEM wait in DRAIN until every outstanding write has retired.
// Writebacks to registers that are not pending raise a sticky wb_err.

module read_hazard_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        v_in,
  input  logic        r_in,
  input  logic        v_wb,
  input  logic [4:0]  WB_address,
  output logic        stall,
  output logic        issue,
  output logic [31:0] busy,
  output logic [3:0]  inflight,
  output logic        draining,
  output logic        wb_err
);

  // Opcode map of the instructions that touch the register file or serialise.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Budget limit in the counter's own width.
  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  inflight_q, inflight_d;
  logic        wb_err_q, wb_err_d;

  logic [6:0]  opcode_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic        use_rs1_s, use_rs2_s, has_rd_s, serial_s;
  logic        writes_rd_s;
  logic        hazard_s, full_s, inflight_nz_s;
  logic        stall_s, issue_s;
  logic        issue_wr_s, wb_live_s, retire_s, collide_s;

  // Fields of IR that no decision looks at.
  logic        unused_ir_bits_s;
  assign unused_ir_bits_s = ^{IR[31:25], IR[14:12]};

  assign opcode_s = IR[6:0];
  assign rd_s     = IR[11:7];
  assign rs1_s    = IR[19:15];
  assign rs2_s    = IR[24:20];

  // Decode which register operands the presented instruction uses.
  always_comb begin
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    has_rd_s  = 1'b0;
    serial_s  = 1'b0;
    case (opcode_s)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        has_rd_s = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        use_rs1_s = 1'b1;
        has_rd_s  = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_OP: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        has_rd_s  = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        serial_s = 1'b1;
      end
      default: begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        has_rd_s  = 1'b0;
        serial_s  = 1'b0;
      end
    endcase
  end

  // A write to x0 is discarded by the register file, so it is not tracked.
  assign writes_rd_s   = has_rd_s & (rd_s != 5'd0);
  assign inflight_nz_s = (inflight_q != 4'd0);
  assign full_s        = writes_rd_s & (inflight_q == MAX_CNT);

  // Hazard check against the registered scoreboard only; a writeback in
  // this same cycle lands at the edge and cannot be forwarded here.
  always_comb begin
    hazard_s = 1'b0;
    if (v_in) begin
      hazard_s = (use_rs1_s & (rs1_s != 5'd0) & busy_q[rs1_s]) |
                 (use_rs2_s & (rs2_s != 5'd0) & busy_q[rs2_s]) |
                 (writes_rd_s & busy_q[rd_s]);
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Next state and stall/issue; stall never looks at r_in, issue needs it.
  always_comb begin
    state_d = state_q;
    stall_s = 1'b1;
    issue_s = 1'b0;
    if (reset) begin
      stall_s = 1'b1;
      issue_s = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (v_in & serial_s & inflight_nz_s) begin
            stall_s = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            stall_s = v_in & (hazard_s | full_s);
            issue_s = v_in & r_in & ~(hazard_s | full_s);
          end
        end
        ST_DRAIN: begin
          if (!v_in) begin
            // Instruction withdrawn: nothing left to serialise.
            stall_s = inflight_nz_s;
            state_d = ST_RUN;
          end else if (inflight_nz_s) begin
            stall_s = 1'b1;
          end else begin
            stall_s = 1'b0;
            issue_s = r_in;
            if (r_in) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
        default: begin
          stall_s = 1'b1;
          issue_s = 1'b0;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Retirement bookkeeping for the writeback port.
  assign wb_live_s  = v_wb & (WB_address != 5'd0);
  assign issue_wr_s = issue_s & writes_rd_s & ~full_s;
  assign retire_s   = wb_live_s & busy_q[WB_address];
  assign collide_s  = issue_wr_s & wb_live_s & (WB_address == rd_s);

  // Scoreboard update: clear on retire first, then a new issue sets its bit
  // so that a forced same-register collision leaves the register pending.
  always_comb begin
    busy_d = busy_q;
    if (retire_s) begin
      busy_d[WB_address] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_wr_s) begin
      busy_d[rd_s] = 1'b1;
    end else begin
      busy_d[rd_s] = busy_d[rd_s];
    end
    busy_d[0] = 1'b0;
  end

  // In-flight count: +1 per tracked issue, -1 per matched retire, net zero
  // when both happen together. Neither path can wrap.
  always_comb begin
    inflight_d = inflight_q;
    case ({issue_wr_s, retire_s})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Sticky error for a writeback to a register that was never pending.
  always_comb begin
    wb_err_d = wb_err_q;
    if (wb_live_s & ~busy_q[WB_address] & ~collide_s) begin
      wb_err_d = 1'b1;
    end else begin
      wb_err_d = wb_err_q;
    end
  end

  // State registers; reset drops every pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      busy_q     <= 32'd0;
      inflight_q <= 4'd0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign stall    = stall_s;
  assign issue    = issue_s;
  assign busy     = busy_q;
  assign inflight = inflight_q;
  assign draining = (state_q == ST_DRAIN);
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_read_hazard_ctrl.sv
// Bench for read_hazard_ctrl: directed scenarios followed by randomized
// traffic, all checked against a set-based reference model of pending writes.

module tb_read_hazard_ctrl;

  localparam int MAX_INF = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IR = 32'd0;
  logic        v_in = 1'b0;
  logic        r_in = 1'b0;
  logic        v_wb = 1'b0;
  logic [4:0]  WB_address = 5'd0;
  logic        stall, issue, draining, wb_err;
  logic [31:0] busy;
  logic [3:0]  inflight;

  read_hazard_ctrl #(.MAX_INFLIGHT(MAX_INF)) dut (
    .clk(clk), .reset(reset), .IR(IR), .v_in(v_in), .r_in(r_in),
    .v_wb(v_wb), .WB_address(WB_address), .stall(stall), .issue(issue),
    .busy(busy), .inflight(inflight), .draining(draining), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: set of pending destination registers, a drain flag, sticky error.
  bit m_pend [32];
  bit m_drain;
  bit m_err;
  bit m_stall, m_issue;
  bit d_u1, d_u2, d_wr, d_ser;
  int d_rs1, d_rs2, d_rd;
  logic obs_stall, obs_issue;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pend_count();
    int c = 0;
    for (int i = 1; i < 32; i++) c += m_pend[i] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = 32'd0;
    for (int i = 1; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction

  // Operand usage straight from the instruction-class table.
  task automatic decode(input logic [31:0] ir);
    d_rd = ir[11:7]; d_rs1 = ir[19:15]; d_rs2 = ir[24:20];
    d_u1 = 0; d_u2 = 0; d_wr = 0; d_ser = 0;
    case (ir[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: d_wr = 1;
      7'b1100111, 7'b0000011, 7'b0010011: begin d_u1 = 1; d_wr = 1; end
      7'b1100011, 7'b0100011: begin d_u1 = 1; d_u2 = 1; end
      7'b0110011: begin d_u1 = 1; d_u2 = 1; d_wr = 1; end
      7'b0001111, 7'b1110011: d_ser = 1;
      default: ;
    endcase
    if (d_rd == 0) d_wr = 0;
  endtask

  task automatic model_eval();
    int cnt;
    bit haz;
    cnt = pend_count();
    decode(IR);
    haz = v_in && ((d_u1 && d_rs1 != 0 && m_pend[d_rs1]) ||
                   (d_u2 && d_rs2 != 0 && m_pend[d_rs2]) ||
                   (d_wr && m_pend[d_rd]));
    if (reset) begin
      m_stall = 1; m_issue = 0;
    end else if (m_drain) begin
      m_stall = (cnt != 0);
      m_issue = v_in && r_in && cnt == 0;
    end else if (v_in && d_ser && cnt != 0) begin
      m_stall = 1; m_issue = 0;
    end else begin
      m_stall = v_in && (haz || (d_wr && cnt == MAX_INF));
      m_issue = v_in && r_in && !m_stall;
    end
  endtask

  task automatic model_update();
    int cnt = pend_count();
    int a = WB_address;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_drain = 0; m_err = 0;
      return;
    end
    if (m_drain) begin
      if (m_issue || !v_in) m_drain = 0;
    end else if (v_in && d_ser && cnt != 0) begin
      m_drain = 1;
    end
    if (v_wb && a != 0) begin
      if (m_issue && d_wr && d_rd == a) begin
        // register is being claimed again this cycle; it stays pending
      end else if (m_pend[a]) m_pend[a] = 0;
      else m_err = 1;
    end
    if (m_issue && d_wr) m_pend[d_rd] = 1;
  endtask

  task automatic step(input logic [31:0] ir_i, input logic v_i, input logic r_i,
                      input logic vwb_i, input int wba_i, input logic rst_i);
    @(negedge clk);
    IR = ir_i; v_in = v_i; r_in = r_i; v_wb = vwb_i; WB_address = 5'(wba_i); reset = rst_i;
    #2;
    model_eval();
    obs_stall = stall; obs_issue = issue;
    check_eq("stall", {31'd0, stall}, {31'd0, m_stall});
    check_eq("issue", {31'd0, issue}, {31'd0, m_issue});
    @(posedge clk);
    #1;
    model_update();
    check_eq("busy", busy, pend_vec());
    check_eq("inflight", {28'd0, inflight}, 32'(pend_count()));
    check_eq("draining", {31'd0, draining}, {31'd0, m_drain});
    check_eq("wb_err", {31'd0, wb_err}, {31'd0, m_err});
  endtask

  task automatic idle(input logic vwb_i, input int wba_i);
    step(32'd0, 1'b0, 1'b1, vwb_i, wba_i, 1'b0);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] op;
    int rd;
    case ($urandom_range(0, 11))
      0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;
      3: op = 7'b1100111;  4: op = 7'b0000011;  5: op = 7'b0010011;
      6: op = 7'b1100011;  7: op = 7'b0100011;  8: op = 7'b0110011;
      9: op = 7'b0001111; 10: op = 7'b1110011;
      default: op = 7'b1111111;
    endcase
    rd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'(rd), op};
  endfunction

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [31:0] FENCE_IR = 32'h0000000F;

  initial begin
    logic [31:0] cur_ir;
    logic        cur_v;
    int          q[$];
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_drain = 0; m_err = 0;

    // Reset state
    step(32'd0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    check_eq("rst_stall", {31'd0, obs_stall}, 32'd1);
    check_eq("rst_issue", {31'd0, obs_issue}, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_inflight", {28'd0, inflight}, 32'd0);

    // 1: RAW on x3 held until its writeback has landed
    step(mk(OPC_OP, 3, 1, 2), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t1_issue_add", {31'd0, obs_issue}, 32'd1);
    step(mk(OPC_OP, 4, 3, 0), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t1_raw_stall", {31'd0, obs_stall}, 32'd1);
    step(mk(OPC_OP, 4, 3, 0), 1'b1, 1'b1, 1'b1, 3, 1'b0);
    check_eq("t1_stall_in_wb_cycle", {31'd0, obs_stall}, 32'd1);
    step(mk(OPC_OP, 4, 3, 0), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t1_issue_after_wb", {31'd0, obs_issue}, 32'd1);
    idle(1'b1, 4);

    // 2: rd == x0 is not tracked; x0 source never hazards
    step(mk(OPC_OP, 0, 5, 6), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t2_issue_x0", {31'd0, obs_issue}, 32'd1);
    check_eq("t2_busy", busy, 32'd0);
    check_eq("t2_inflight", {28'd0, inflight}, 32'd0);
    step({12'd1, 5'd0, 3'd0, 5'd7, OPC_IMM}, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t2_issue_addi", {31'd0, obs_issue}, 32'd1);
    idle(1'b1, 7);

    // 3: in-flight budget
    for (int i = 1; i <= 4; i++) begin
      step({20'h00001, 5'(i), OPC_LUI}, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      check_eq("t3_issue_lui", {31'd0, obs_issue}, 32'd1);
    end
    step({20'h00001, 5'd5, OPC_LUI}, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t3_full_stall", {31'd0, obs_stall}, 32'd1);
    check_eq("t3_inflight_full", {28'd0, inflight}, 32'd4);
    step({20'h00001, 5'd5, OPC_LUI}, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    check_eq("t3_stall_wb_cycle", {31'd0, obs_stall}, 32'd1);
    step({20'h00001, 5'd5, OPC_LUI}, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t3_issue_fifth", {31'd0, obs_issue}, 32'd1);
    check_eq("t3_inflight_after", {28'd0, inflight}, 32'd4);
    for (int i = 2; i <= 5; i++) idle(1'b1, i);

    // 4: FENCE drains before issuing
    step({20'h00001, 5'd8, OPC_LUI}, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(FENCE_IR, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t4_fence_stall", {31'd0, obs_stall}, 32'd1);
    check_eq("t4_draining", {31'd0, draining}, 32'd1);
    step(FENCE_IR, 1'b1, 1'b1, 1'b1, 8, 1'b0);
    check_eq("t4_stall_wb_cycle", {31'd0, obs_stall}, 32'd1);
    step(FENCE_IR, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("t4_fence_issue", {31'd0, obs_issue}, 32'd1);
    check_eq("t4_back_to_run", {31'd0, draining}, 32'd0);

    // 5: stray writeback sets a sticky error that only reset clears
    idle(1'b1, 9);
    check_eq("t5_wb_err", {31'd0, wb_err}, 32'd1);
    check_eq("t5_inflight", {28'd0, inflight}, 32'd0);
    idle(1'b0, 0);
    check_eq("t5_wb_err_sticky", {31'd0, wb_err}, 32'd1);
    step({20'h00001, 5'd2, OPC_LUI}, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    check_eq("t5_rst_issue", {31'd0, obs_issue}, 32'd0);
    check_eq("t5_wb_err_cleared", {31'd0, wb_err}, 32'd0);
    check_eq("t5_busy_cleared", busy, 32'd0);

    // 6: issue and retire in the same cycle
    step({20'h00001, 5'd11, OPC_LUI}, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step({20'h00001, 5'd12, OPC_LUI}, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step({20'h00001, 5'd10, OPC_LUI}, 1'b1, 1'b1, 1'b1, 11, 1'b0);
    check_eq("t6_issue", {31'd0, obs_issue}, 32'd1);
    check_eq("t6_inflight", {28'd0, inflight}, 32'd2);
    check_eq("t6_busy10", {31'd0, busy[10]}, 32'd1);
    check_eq("t6_busy11", {31'd0, busy[11]}, 32'd0);
    step(32'd0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Randomized traffic; a presented instruction is held until it issues.
    cur_ir = rand_ir();
    cur_v = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic vwb;
      int   wba;
      logic rst_i;
      if (!(cur_v && !m_issue) || cyc == 0) begin
        cur_v = ($urandom_range(0, 9) < 7);
        cur_ir = rand_ir();
      end
      q.delete();
      for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
      vwb = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 9) < 9) wba = q[$urandom_range(0, q.size() - 1)];
      else wba = $urandom_range(0, 31);
      rst_i = ($urandom_range(0, 199) == 0);
      step(cur_ir, cur_v, 1'($urandom_range(0, 3) != 0), vwb, wba, rst_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
